// File: rtl/act_arb_pkg.sv
// Shared types and helpers for the activation-unit arbiter.
package act_arb_pkg;

    localparam int unsigned NReqDefault     = 4;
    localparam int unsigned DataBitsDefault = 16;
    localparam int unsigned CntBitsDefault  = 16;

    // Index type is sized for the largest supported requester count (8) so that one
    // helper serves every legal N_REQ.
    localparam int unsigned MaxReq     = 8;
    localparam int unsigned MaxIdxBits = 3;

    typedef logic [DataBitsDefault-1:0] act_data_t;
    typedef logic [MaxIdxBits-1:0]      req_idx_t;

    // One-hot decode of a requester index; callers truncate to their own N_REQ.
    function automatic logic [MaxReq-1:0] onehot(req_idx_t idx);
        logic [MaxReq-1:0] vec;
        vec      = '0;
        vec[idx] = 1'b1;
        return vec;
    endfunction

endpackage

// File: rtl/act_unit_arbiter_rr.sv
// Round-robin arbiter: first requester at or after the pointer wins, wrapping at N_REQ.
module rr_arbiter #(
    parameter int unsigned  N_REQ = 4,
    localparam int unsigned IdxW  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IdxW-1:0]  ptr_i,
    input  logic             en_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [IdxW-1:0]  idx_o
);

    logic            found;
    logic [IdxW:0]   sum;
    logic [IdxW-1:0] lane;

    // Rotating priority search; the extra sum bit lets non-power-of-two counts wrap exactly.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        sum   = '0;
        lane  = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            sum = {1'b0, ptr_i} + (IdxW+1)'(k);
            if (sum >= (IdxW+1)'(N_REQ)) begin
                sum = sum - (IdxW+1)'(N_REQ);
            end
            lane = sum[IdxW-1:0];
            if (en_i && !found && req_i[lane]) begin
                found       = 1'b1;
                gnt_o[lane] = 1'b1;
                idx_o       = lane;
            end
        end
    end

endmodule

// File: rtl/act_unit_arbiter.sv
// Shares one combinational activation unit between N_REQ requesters through a two-stage
// pipe: S1 holds the operand driving the unit, S2 holds the result awaiting its owner.
module act_unit_arbiter
    import act_arb_pkg::*;
#(
    parameter int unsigned N_REQ     = NReqDefault,
    parameter int unsigned DATA_BITS = DataBitsDefault,
    parameter int unsigned CNT_BITS  = CntBitsDefault
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_REQ-1:0]           req_valid_i,
    input  logic [N_REQ*DATA_BITS-1:0] req_data_i,
    output logic [N_REQ-1:0]           req_ready_o,
    output logic [DATA_BITS-1:0]       unit_x_o,
    input  logic [DATA_BITS-1:0]       unit_y_i,
    output logic [N_REQ-1:0]           rsp_valid_o,
    output logic [DATA_BITS-1:0]       rsp_data_o,
    input  logic [N_REQ-1:0]           rsp_ready_i,
    output logic [CNT_BITS-1:0]        acc_count_o
);

    localparam int unsigned IdxW = $clog2(N_REQ);

    logic [IdxW-1:0]      ptr_q, ptr_d;
    logic                 s1_valid_q, s1_valid_d;
    logic [IdxW-1:0]      s1_owner_q, s1_owner_d;
    logic [DATA_BITS-1:0] unit_x_q, unit_x_d;
    logic [N_REQ-1:0]     rsp_valid_q, rsp_valid_d;
    logic [DATA_BITS-1:0] rsp_data_q, rsp_data_d;
    logic [CNT_BITS-1:0]  acc_q, acc_d;

    logic                 s2_busy, s2_done, s2_free;
    logic                 s1_adv, s1_load_en, accept;
    logic [N_REQ-1:0]     gnt;
    logic [IdxW-1:0]      gnt_idx;
    logic [DATA_BITS-1:0] operand;

    // Pipe occupancy: S2 frees when empty or its owner takes the result this cycle.
    always_comb begin
        s2_busy    = |rsp_valid_q;
        s2_done    = |(rsp_valid_q & rsp_ready_i);
        s2_free    = !s2_busy || s2_done;
        s1_adv     = s1_valid_q && s2_free;
        s1_load_en = !s1_valid_q || s2_free;
    end

    rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_rr_arbiter (
        .req_i (req_valid_i),
        .ptr_i (ptr_q),
        .en_i  (s1_load_en),
        .gnt_o (gnt),
        .idx_o (gnt_idx)
    );

    // Operand mux driven by the one-hot grant.
    always_comb begin
        operand = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (gnt[i]) begin
                operand = req_data_i[i*DATA_BITS +: DATA_BITS];
            end
        end
    end

    // Next state for both stages, pointer and counter.
    always_comb begin
        accept      = |gnt;
        ptr_d       = ptr_q;
        s1_valid_d  = s1_valid_q;
        s1_owner_d  = s1_owner_q;
        unit_x_d    = unit_x_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        acc_d       = acc_q;

        if (accept) begin
            // unit_x only changes on an accept so an idle unit sees no input toggles.
            unit_x_d   = operand;
            s1_owner_d = gnt_idx;
            s1_valid_d = 1'b1;
            ptr_d      = (gnt_idx == IdxW'(N_REQ - 1)) ? '0 : gnt_idx + IdxW'(1);
            acc_d      = acc_q + CNT_BITS'(1);
        end else if (s1_adv) begin
            s1_valid_d = 1'b0;
        end

        if (s1_adv) begin
            rsp_data_d  = unit_y_i;
            rsp_valid_d = N_REQ'(onehot(req_idx_t'(s1_owner_q)));
        end else if (s2_done) begin
            // rsp_data keeps its last value; only the valid drops.
            rsp_valid_d = '0;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q       <= '0;
            s1_valid_q  <= 1'b0;
            s1_owner_q  <= '0;
            unit_x_q    <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            acc_q       <= '0;
        end else begin
            ptr_q       <= ptr_d;
            s1_valid_q  <= s1_valid_d;
            s1_owner_q  <= s1_owner_d;
            unit_x_q    <= unit_x_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            acc_q       <= acc_d;
        end
    end

    assign req_ready_o = gnt;
    assign unit_x_o    = unit_x_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = rsp_data_q;
    assign acc_count_o = acc_q;

endmodule
